iq_player_1cic: RTL and testbench
=================================

# iq_player_1cic

Transmit-direction counterpart of the waterfall receive chain: accepts baseband I/Q sample pairs written at a low rate, buffers them in a small FIFO, and runs a variable-ratio CIC interpolator to deliver one I/Q pair per adc_clk. Sits between the CPU-side sample loader and a downstream upconverter/DAC path, in the adc_clk domain only. Software sets the interpolation ratio and keeps the FIFO fed; the block flags underrun and overrun.

## Interface
- IN_WIDTH, 16, input sample width (signed), also FIFO data width per channel
- OUT_WIDTH, 16, output sample width (signed)
- STAGES, 3, CIC stages N (M=1)
- MAX_INTERP, 1024, maximum ratio R, power of 2
- FIFO_AW, 5, FIFO address width; depth 2^FIFO_AW pairs
- adc_clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- set_interp  in  1  load interp on this cycle
- interp  in  MI = clog2(MAX_INTERP)+1  ratio 1..MAX_INTERP; 0 treated as 1
- run  in  1  enable interpolation
- wr  in  1  push one I/Q pair
- wr_i, wr_q  in  IN_WIDTH  samples pushed with wr
- clr_flags  in  1  clear sticky flags
- fifo_full  out  1  FIFO holds 2^FIFO_AW pairs
- fifo_count  out  FIFO_AW+1  pairs held
- underrun, overrun  out  1  sticky error flags
- tick  out  1  one-cycle pulse on each low-rate pop slot
- out_i, out_q  out  OUT_WIDTH  interpolated output, new value every cycle

## Operation
- Reset: FIFO empty, fifo_count=0, interp reg=1, rate counter=0, all comb/integrator regs 0, out_i/out_q=0, tick=0, flags 0.
- Rate counter: when run=1, tick asserts when counter==0, counter reloads interp_reg-1; else decrements. run=0 forces counter to 0, tick=0; CIC state held (integrators receive zero input, values keep accumulating that zero, i.e. hold).
- set_interp updates interp_reg only; takes effect at next reload, counter not restarted.
- On tick: pop one pair if FIFO non-empty; if empty, feed zeros to combs and set underrun. No fall-through: a pair written on the tick cycle into an empty FIFO is not consumed that cycle.
- wr while full and no simultaneous pop: pair dropped, overrun set. wr while full with simultaneous pop: accepted, count unchanged.
- clr_flags clears both flags; a new error event in the same cycle wins (flag stays 1).
- CIC per channel: N comb stages clocked on tick-delayed enables, then zero-stuffing (comb output presented on the stuffed cycle, zero otherwise), then N integrators every cycle.
- Internal width W = IN_WIDTH + STAGES*clog2(MAX_INTERP); two's-complement wrap-around, no saturation.
- Gain R^(N-1); scaling fixed for MAX_INTERP: out = last_integrator[IN_WIDTH+(STAGES-1)*clog2(MAX_INTERP)-1 -: OUT_WIDTH]. Lower ratios give proportionally smaller output; software compensates.

## Timing
- FIFO read data registered: 1 cycle after tick.
- Each comb stage and each integrator registered: latency from tick at cycle t to first influence on out_i/out_q at cycle t+2*STAGES+1.
- fifo_count/fifo_full update the cycle after wr/pop; flags assert the cycle after the event.
- I and Q channels cycle-aligned exactly.

## Structure
- STAGES/MAX_INTERP defaults and clog2 belong in the shared include (kiwi.vh) as TX1_STAGES, TX_1CIC_MAXI.
- Sub-module cic_interp_var: one channel (combs, zero-stuff, integrators, output slice), instantiated for I and Q; FIFO and rate counter stay in the top.

## Test plan
- Defaults, interp=1024, run=1, FIFO kept fed with I=1000, Q=-1000 -> out_i settles to 1000, out_q to -1000 (±1 LSB); tick every 1024 cycles.
- interp=4, push single pair I=2^15-1 then zeros -> impulse response equals reference CIC model, first nonzero out at tick+7.
- run=1 with empty FIFO -> underrun=1 one cycle after first tick; clr_flags with no event -> 0; clr_flags coinciding with tick on empty -> stays 1.
- 33 writes with no pops (AW=5) -> fifo_full=1, count=32, overrun=1; write plus pop at full -> count stays 32, no overrun.
- interp 8 changed to 16 mid-run -> current 8-cycle interval completes, next intervals 16; interp=0 -> tick every cycle.
- reset asserted mid-stream -> next cycle outputs 0, count 0, flags 0, interp reg 1.

Source files
------------

// File: rtl/iq_player_1cic_pkg.sv
// ---------------------------------------------------------------------------
// iq_player_1cic_pkg
// Shared constants for the transmit I/Q player: default CIC stage count,
// default maximum interpolation ratio, and a ceil(log2) helper that sizes
// the ratio port and the CIC bit growth.
// ---------------------------------------------------------------------------
package iq_player_1cic_pkg;

  localparam int TX1_STAGES   = 3;
  localparam int TX_1CIC_MAXI = 1024;

  // ceil(log2(value)); value 1 gives 0
  function automatic int tx1Clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cic_interp_var.sv
// ---------------------------------------------------------------------------
// cic_interp_var
// One channel of the variable-ratio CIC interpolator (differential delay 1).
// STAGES comb sections run on the low-rate enable, the last comb output is
// zero-stuffed up to the adc_clk rate, then STAGES integrators run every
// cycle. The output is a fixed slice sized for the maximum ratio.
//
// Ports
//   i_clk    sole clock
//   i_reset  synchronous, active-high
//   i_en     low-rate strobe, i_x is valid on this cycle
//   i_x      signed low-rate input sample
//   o_y      signed interpolated output, one per clock
// ---------------------------------------------------------------------------
module cic_interp_var
  import iq_player_1cic_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int STAGES    = TX1_STAGES,
  parameter int LOG_MAXI  = tx1Clog2(TX_1CIC_MAXI)
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_en,
  input  logic signed [IN_WIDTH-1:0]  i_x,
  output logic signed [OUT_WIDTH-1:0] o_y
);

  localparam int W   = IN_WIDTH + STAGES * LOG_MAXI;
  localparam int MSB = IN_WIDTH + (STAGES - 1) * LOG_MAXI - 1;

  logic signed [W-1:0] r_dly   [STAGES];
  logic signed [W-1:0] r_comb  [STAGES];
  logic signed [W-1:0] r_integ [STAGES];
  logic        [STAGES-1:0] r_en;

  logic signed [W-1:0] w_combIn [STAGES];
  logic signed [W-1:0] w_intIn  [STAGES];
  logic        [STAGES-1:0] w_combEn;

  // Chain wiring: each comb stage sees the previous stage and that stage's
  // delayed enable; the first integrator sees the zero-stuffed comb output,
  // which is only nonzero on the cycle the last comb stage produced a value.
  always_comb begin
    w_combIn[0] = {{(W - IN_WIDTH){i_x[IN_WIDTH-1]}}, i_x};
    w_combEn[0] = i_en;
    w_intIn[0]  = r_en[STAGES-1] ? r_comb[STAGES-1] : '0;
    for (int k = 1; k < STAGES; k++) begin
      w_combIn[k] = r_comb[k-1];
      w_combEn[k] = r_en[k-1];
      w_intIn[k]  = r_integ[k-1];
    end
  end

  // Comb stages advance only on their own enable so their delay elements
  // span one low-rate sample; integrators accumulate every cycle and wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_en <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_dly[k]   <= '0;
        r_comb[k]  <= '0;
        r_integ[k] <= '0;
      end
    end else begin
      r_en <= w_combEn;
      for (int k = 0; k < STAGES; k++) begin
        if (w_combEn[k]) begin
          r_dly[k]  <= w_combIn[k];
          r_comb[k] <= w_combIn[k] - r_dly[k];
        end
        r_integ[k] <= r_integ[k] + w_intIn[k];
      end
    end
  end

  // Gain is R^(STAGES-1); dropping (STAGES-1)*LOG_MAXI LSBs normalises it
  // for the maximum ratio only.
  assign o_y = r_integ[STAGES-1][MSB -: OUT_WIDTH];

endmodule

// File: rtl/iq_player_1cic.sv
// ---------------------------------------------------------------------------
// iq_player_1cic
// Transmit-side I/Q player: CPU-loaded sample pairs go into a small FIFO,
// a rate counter pops one pair per interpolation interval, and a CIC
// interpolator per channel produces one I/Q pair per adc_clk.
//
// Ports
//   i_adc_clk     sole clock
//   i_reset       synchronous, active-high
//   i_set_interp  load i_interp into the ratio register
//   i_interp      ratio 1..MAX_INTERP, 0 is treated as 1
//   i_run         enable the rate counter
//   i_wr          push (i_wr_i, i_wr_q)
//   i_clr_flags   clear sticky underrun/overrun
//   o_fifo_full   FIFO holds 2^FIFO_AW pairs
//   o_fifo_count  pairs held
//   o_underrun    sticky: pop slot found the FIFO empty
//   o_overrun     sticky: write dropped because the FIFO was full
//   o_tick        one-cycle pulse on each low-rate pop slot
//   o_out_i/q     interpolated output
// ---------------------------------------------------------------------------
module iq_player_1cic
  import iq_player_1cic_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int STAGES     = TX1_STAGES,
  parameter int MAX_INTERP = TX_1CIC_MAXI,
  parameter int FIFO_AW    = 5,
  parameter int MI         = tx1Clog2(MAX_INTERP) + 1
) (
  input  logic                        i_adc_clk,
  input  logic                        i_reset,
  input  logic                        i_set_interp,
  input  logic [MI-1:0]               i_interp,
  input  logic                        i_run,
  input  logic                        i_wr,
  input  logic signed [IN_WIDTH-1:0]  i_wr_i,
  input  logic signed [IN_WIDTH-1:0]  i_wr_q,
  input  logic                        i_clr_flags,
  output logic                        o_fifo_full,
  output logic [FIFO_AW:0]            o_fifo_count,
  output logic                        o_underrun,
  output logic                        o_overrun,
  output logic                        o_tick,
  output logic signed [OUT_WIDTH-1:0] o_out_i,
  output logic signed [OUT_WIDTH-1:0] o_out_q
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [MI-1:0]              r_interp;
  logic [MI-1:0]              r_cnt;
  logic [IN_WIDTH-1:0]        r_memI [DEPTH];
  logic [IN_WIDTH-1:0]        r_memQ [DEPTH];
  logic [FIFO_AW-1:0]         r_wrPtr;
  logic [FIFO_AW-1:0]         r_rdPtr;
  logic [FIFO_AW:0]           r_count;
  logic signed [IN_WIDTH-1:0] r_popI;
  logic signed [IN_WIDTH-1:0] r_popQ;
  logic                       r_popValid;
  logic                       r_underrun;
  logic                       r_overrun;

  logic w_tick;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_underEv;
  logic w_overEv;

  // A write into a full FIFO is still accepted when the same cycle pops,
  // because the freed slot is the one being written.
  assign w_tick    = i_run && (r_cnt == '0) && !i_reset;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (FIFO_AW + 1)'(DEPTH));
  assign w_pop     = w_tick && !w_empty;
  assign w_push    = i_wr && (!w_full || w_pop);
  assign w_underEv = w_tick && w_empty;
  assign w_overEv  = i_wr && w_full && !w_pop;

  // Rate counter: a new ratio is only picked up at the next reload, so an
  // interval already in progress always finishes at its old length.
  always_ff @(posedge i_adc_clk) begin
    if (i_reset) begin
      r_interp <= MI'(1);
      r_cnt    <= '0;
    end else begin
      if (i_set_interp) begin
        r_interp <= (i_interp == '0) ? MI'(1) : i_interp;
      end
      if (!i_run) begin
        r_cnt <= '0;
      end else if (r_cnt == '0) begin
        r_cnt <= r_interp - MI'(1);
      end else begin
        r_cnt <= r_cnt - MI'(1);
      end
    end
  end

  // Sample storage has no reset; only pointers and count define contents.
  always_ff @(posedge i_adc_clk) begin
    if (w_push) begin
      r_memI[r_wrPtr] <= i_wr_i;
      r_memQ[r_wrPtr] <= i_wr_q;
    end
  end

  // FIFO bookkeeping plus the registered read port. Every tick produces a
  // valid strobe to the CIC; an empty FIFO supplies zeros instead of data.
  always_ff @(posedge i_adc_clk) begin
    if (i_reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_popI     <= '0;
      r_popQ     <= '0;
      r_popValid <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_popValid <= w_tick;
      r_popI     <= w_pop ? signed'(r_memI[r_rdPtr]) : '0;
      r_popQ     <= w_pop ? signed'(r_memQ[r_rdPtr]) : '0;
    end
  end

  // Sticky error flags; an event in the clearing cycle keeps the flag set.
  always_ff @(posedge i_adc_clk) begin
    if (i_reset) begin
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_underrun <= w_underEv || (r_underrun && !i_clr_flags);
      r_overrun  <= w_overEv  || (r_overrun  && !i_clr_flags);
    end
  end

  cic_interp_var #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .STAGES    (STAGES),
    .LOG_MAXI  (tx1Clog2(MAX_INTERP))
  ) u_cicI (
    .i_clk   (i_adc_clk),
    .i_reset (i_reset),
    .i_en    (r_popValid),
    .i_x     (r_popI),
    .o_y     (o_out_i)
  );

  cic_interp_var #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .STAGES    (STAGES),
    .LOG_MAXI  (tx1Clog2(MAX_INTERP))
  ) u_cicQ (
    .i_clk   (i_adc_clk),
    .i_reset (i_reset),
    .i_en    (r_popValid),
    .i_x     (r_popQ),
    .o_y     (o_out_q)
  );

  assign o_fifo_full  = w_full;
  assign o_fifo_count = r_count;
  assign o_underrun   = r_underrun;
  assign o_overrun    = r_overrun;
  assign o_tick       = w_tick;

endmodule

// File: tb/tb_iq_player_1cic.sv
// ---------------------------------------------------------------------------
// tb_iq_player_1cic
// Directed bench for iq_player_1cic: reset state, underrun and flag
// clearing, FIFO full/overrun, CIC impulse and DC response, ratio changes
// and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_iq_player_1cic;

  localparam int MI = 11;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               setInterp = 1'b0;
  logic [MI-1:0]      interp = '0;
  logic               run = 1'b0;
  logic               wr = 1'b0;
  logic signed [15:0] wrI = '0;
  logic signed [15:0] wrQ = '0;
  logic               clrFlags = 1'b0;

  logic               fifoFull;
  logic [5:0]         fifoCount;
  logic               underrun;
  logic               overrun;
  logic               tick;
  logic signed [15:0] outI;
  logic signed [15:0] outQ;

  int vectorCount = 0;
  int missCount   = 0;

  iq_player_1cic dut (
    .i_adc_clk    (clk),
    .i_reset      (reset),
    .i_set_interp (setInterp),
    .i_interp     (interp),
    .i_run        (run),
    .i_wr         (wr),
    .i_wr_i       (wrI),
    .i_wr_q       (wrQ),
    .i_clr_flags  (clrFlags),
    .o_fifo_full  (fifoFull),
    .o_fifo_count (fifoCount),
    .o_underrun   (underrun),
    .o_overrun    (overrun),
    .o_tick       (tick),
    .o_out_i      (outI),
    .o_out_q      (outQ)
  );

  always #5 clk = ~clk;

  // Advance the given number of clock edges and settle just past the last
  task automatic applyStimulus(input int nCycles);
    for (int n = 0; n < nCycles; n++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single comparison point; counts every vector and reports mismatches
  task automatic checkOutput(input string tag, input longint observed,
                             input longint expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    run = 1'b0; wr = 1'b0; setInterp = 1'b0; clrFlags = 1'b0;
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(3);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("rst_out_i", outI, 0);
    checkOutput("rst_out_q", outQ, 0);
    checkOutput("rst_count", fifoCount, 0);
    checkOutput("rst_full", fifoFull, 0);
    checkOutput("rst_underrun", underrun, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_tick", tick, 0);

    // underrun on empty FIFO, then clearing behaviour
    run = 1'b1;
    #1;
    checkOutput("first_tick", tick, 1);
    applyStimulus(1);
    checkOutput("underrun_set", underrun, 1);
    run = 1'b0; clrFlags = 1'b1;
    applyStimulus(1);
    clrFlags = 1'b0;
    checkOutput("underrun_clr", underrun, 0);
    run = 1'b1; clrFlags = 1'b1;
    applyStimulus(1);
    checkOutput("clr_vs_event", underrun, 1);
    run = 1'b0; clrFlags = 1'b0;

    // fill to full, then one more write is dropped
    doReset();
    for (int k = 0; k < 33; k++) begin
      wr = 1'b1; wrI = 16'(100 + k); wrQ = 16'(-100 - k);
      applyStimulus(1);
      if (k == 31) begin
        checkOutput("fill_count32", fifoCount, 32);
        checkOutput("fill_full", fifoFull, 1);
        checkOutput("fill_no_overrun", overrun, 0);
      end
    end
    wr = 1'b0;
    checkOutput("ovr_count", fifoCount, 32);
    checkOutput("ovr_flag", overrun, 1);
    clrFlags = 1'b1;
    applyStimulus(1);
    clrFlags = 1'b0;
    checkOutput("ovr_clr", overrun, 0);
    wr = 1'b1; run = 1'b1; wrI = 16'sd7;
    applyStimulus(1);
    wr = 1'b0; run = 1'b0;
    checkOutput("wrpop_count", fifoCount, 32);
    checkOutput("wrpop_full", fifoFull, 1);
    checkOutput("wrpop_overrun", overrun, 0);
    checkOutput("wrpop_underrun", underrun, 0);

    // impulse through R=4: floor(-32768*h/2^20) = -1 for h in 1..12
    doReset();
    setInterp = 1'b1; interp = 11'd4;
    applyStimulus(1);
    setInterp = 1'b0;
    wr = 1'b1; wrI = -16'sd32768; wrQ = 16'sd32767;
    applyStimulus(1);
    wr = 1'b0;
    run = 1'b1;
    #1;
    checkOutput("imp_tick", tick, 1);
    applyStimulus(6);
    checkOutput("imp_t6_i", outI, 0);
    applyStimulus(1);
    checkOutput("imp_t7_i", outI, -1);
    checkOutput("imp_t7_q", outQ, 0);
    applyStimulus(4);
    checkOutput("imp_t11_i", outI, -1);
    checkOutput("imp_t11_q", outQ, 0);
    applyStimulus(5);
    checkOutput("imp_t16_i", outI, -1);
    applyStimulus(1);
    checkOutput("imp_t17_i", outI, 0);
    checkOutput("imp_underrun", underrun, 1);
    run = 1'b0;

    // ratio 8, changed to 16 mid-interval, then 0 (acts as 1)
    doReset();
    setInterp = 1'b1; interp = 11'd8;
    applyStimulus(1);
    setInterp = 1'b0;
    run = 1'b1;
    for (int c = 0; c < 46; c++) begin
      setInterp = (c == 3) || (c == 30);
      interp    = (c == 30) ? 11'd0 : 11'd16;
      #1;
      checkOutput($sformatf("ivl_tick_c%0d", c), tick,
                  (c == 0 || c == 8 || c == 24 || c == 40 || c >= 41) ? 1 : 0);
      applyStimulus(1);
    end
    setInterp = 1'b0; run = 1'b0;

    // DC at R=1024: gain 2^20 cancels the fixed slice exactly
    doReset();
    setInterp = 1'b1; interp = 11'd1024;
    applyStimulus(1);
    setInterp = 1'b0;
    wrI = 16'sd1000; wrQ = -16'sd1000; wr = 1'b1;
    applyStimulus(8);
    wr = 1'b0;
    checkOutput("dc_prefill", fifoCount, 8);
    run = 1'b1;
    for (int c = 0; c < 6 * 1024 + 16; c++) begin
      wr = (fifoCount < 8);
      #1;
      if (tick || (c % 1024) == 0)
        checkOutput($sformatf("dc_tick_c%0d", c), tick, ((c % 1024) == 0) ? 1 : 0);
      if (c >= 5 * 1024 + 16 && (c % 128) == 0) begin
        checkOutput("dc_out_i", outI, 1000);
        checkOutput("dc_out_q", outQ, -1000);
      end
      applyStimulus(1);
    end
    checkOutput("dc_underrun", underrun, 0);
    checkOutput("dc_overrun", overrun, 0);

    // stop, overfill, then reset mid-stream
    run = 1'b0; wr = 1'b0;
    applyStimulus(20);
    checkOutput("hold_out_i", outI, 1000);
    wr = 1'b1;
    applyStimulus(40);
    wr = 1'b0;
    checkOutput("pre_rst_overrun", overrun, 1);
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    checkOutput("mid_rst_out_i", outI, 0);
    checkOutput("mid_rst_out_q", outQ, 0);
    checkOutput("mid_rst_count", fifoCount, 0);
    checkOutput("mid_rst_full", fifoFull, 0);
    checkOutput("mid_rst_overrun", overrun, 0);
    checkOutput("mid_rst_underrun", underrun, 0);
    run = 1'b1;
    #1;
    checkOutput("mid_rst_tick0", tick, 1);
    applyStimulus(1);
    checkOutput("mid_rst_tick1", tick, 1);
    applyStimulus(1);
    checkOutput("mid_rst_tick2", tick, 1);
    run = 1'b0;
    applyStimulus(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
